// File: rtl/button_conditioner_pkg.sv
// Shared constants, types and helpers for the quiz-button conditioner.
// Used by the interface, the per-button debouncer and the top level.
package button_conditioner_pkg;

  localparam int          NUM_BTN          = 7;
  localparam int          DEBOUNCE_DEFAULT = 200_000;
  localparam logic [2:0]  CODE_NONE        = 3'd0;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  // 1-based index of the lowest set bit, CODE_NONE when the vector is empty.
  function automatic logic [2:0] lowest_code(input btn_vec_t v);
    lowest_code = CODE_NONE;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) lowest_code = 3'(i + 1);
    end
  endfunction

  function automatic btn_vec_t lowest_bit(input btn_vec_t v);
    return v & btn_vec_t'(~v + 1'b1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus between the raw pins / consumer (master) and the conditioner (slave).
interface button_conditioner_if;
  import button_conditioner_pkg::*;

  btn_vec_t   btn_raw;
  btn_vec_t   btn_level;
  btn_vec_t   btn_pulse;
  logic [2:0] btn_code;
  logic       any_pulse;

  modport master (output btn_raw, input btn_level, btn_pulse, btn_code, any_pulse);
  modport slave  (input btn_raw, output btn_level, btn_pulse, btn_code, any_pulse);

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button: two-flop synchroniser, persistence counter and stable level.
// `rise` is a combinational strobe, high on the cycle before `stable` goes 0->1.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise,
  output logic stable
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  assign rise = sync && !stable && (cnt == CNT_MAX);

  // NOTE: non-blocking assignments keep meta->sync a true two-stage shift;
  // blocking ones would collapse the synchroniser into a single flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Quiz-button conditioner: debounced levels, one-cycle press pulses, priority code.
// Define BTN_SINGLE_PRESS_EN to allow at most one press pulse while no other button is held.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  bus
);

  btn_vec_t   rise;
  btn_vec_t   stable;
  btn_vec_t   pulse_d;
  btn_vec_t   pulse_q;
  logic [2:0] code_q;
  logic       any_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .raw    (bus.btn_raw[i]),
      .rise   (rise[i]),
      .stable (stable[i])
    );
  end

`ifdef BTN_SINGLE_PRESS_EN
  // A rising channel's own level is still 0, so any high level belongs to another button.
  always_comb begin
    pulse_d = '0;
    if (stable == '0) pulse_d = lowest_bit(rise);
  end
`else
  always_comb begin
    pulse_d = rise;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_q <= '0;
      code_q  <= CODE_NONE;
      any_q   <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      code_q  <= lowest_code(pulse_d);
      any_q   <= |pulse_d;
    end
  end

  assign bus.btn_level = stable;
  assign bus.btn_pulse = pulse_q;
  assign bus.btn_code  = code_q;
  assign bus.any_pulse = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4: directed scenarios plus random
// bouncing, every cycle compared against a sliding-window reference model.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int D = 4;

  logic     clk   = 1'b0;
  logic     reset = 1'b1;
  btn_vec_t raw   = '0;

  always #5 clk = ~clk;

  button_conditioner_if bus();
  assign bus.btn_raw = raw;

  button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: raw samples of the last D+2 edges; a level flips once the D most recent
  // synchronised samples (raw delayed two edges) all disagree with it.
  btn_vec_t   hist [D+2];
  btn_vec_t   m_level;
  btn_vec_t   m_pulse;
  logic [2:0] m_code;
  int         dut_cnt [NUM_BTN];
  int         hold    [NUM_BTN];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < D + 2; k++) hist[k] = '0;
    m_level = '0;
    m_pulse = '0;
    m_code  = 3'd0;
  endtask

  task automatic model_edge();
    btn_vec_t all1, all0, rises, falls;
    for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = raw;
    all1 = '1;
    all0 = '1;
    for (int k = 2; k <= D + 1; k++) begin
      all1 &= hist[k];
      all0 &= ~hist[k];
    end
    rises = ~m_level & all1;
    falls =  m_level & all0;
`ifdef BTN_SINGLE_PRESS_EN
    m_pulse = '0;
    if (m_level == '0) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (rises[i]) begin
          m_pulse[i] = 1'b1;
          break;
        end
      end
    end
`else
    m_pulse = rises;
`endif
    m_level = (m_level | rises) & ~falls;
    m_code  = 3'd0;
    for (int i = NUM_BTN - 1; i >= 0; i--) if (m_pulse[i]) m_code = 3'(i + 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < NUM_BTN; i++) if (bus.btn_pulse[i] === 1'b1) dut_cnt[i]++;
    check("level", 32'(bus.btn_level), 32'(m_level));
    check("pulse", 32'(bus.btn_pulse), 32'(m_pulse));
    check("code",  32'(bus.btn_code),  32'(m_code));
    check("any",   32'(bus.any_pulse), 32'(|m_pulse));
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < NUM_BTN; i++) dut_cnt[i] = 0;
  endtask

  // Asserts reset for one clock edge; outputs must clear without waiting for an edge.
  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_level", 32'(bus.btn_level), 32'd0);
    check("rst_pulse", 32'(bus.btn_pulse), 32'd0);
    check("rst_code",  32'(bus.btn_code),  32'd0);
    check("rst_any",   32'(bus.any_pulse), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    clr_cnt();
    do_reset();

    // Single press on bit 2: pulse and level after edge 6.
    raw = 7'b0000100;
    ticks(5);
    check("s1_no_early_pulse", 32'(bus.btn_pulse), 32'd0);
    tick();
    check("s1_pulse", 32'(bus.btn_pulse), 32'h04);
    check("s1_code",  32'(bus.btn_code),  32'd3);
    check("s1_any",   32'(bus.any_pulse), 32'd1);
    tick();
    check("s1_pulse_one_cycle", 32'(bus.btn_pulse), 32'd0);
    check("s1_level_held",      32'(bus.btn_level[2]), 32'd1);
    ticks(3);
    raw = '0;
    ticks(8);

    // Width D-1 is rejected, width D is accepted; release gives no pulse.
    clr_cnt();
    raw = 7'b0000001;
    ticks(3);
    raw = '0;
    ticks(10);
    check("s2_short_no_pulse", 32'(dut_cnt[0]), 32'd0);
    check("s2_short_no_level", 32'(bus.btn_level), 32'd0);
    raw = 7'b0000001;
    ticks(4);
    raw = '0;
    ticks(2);
    check("s2_min_width_level", 32'(bus.btn_level[0]), 32'd1);
    ticks(10);
    check("s2_one_pulse", 32'(dut_cnt[0]), 32'd1);
    check("s2_fell",      32'(bus.btn_level[0]), 32'd0);

    // Bounce on bit 4: 1,0,1,0 then held.
    clr_cnt();
    raw = 7'b0010000; tick();
    raw = '0;         tick();
    raw = 7'b0010000; tick();
    raw = '0;         tick();
    raw = 7'b0010000;
    ticks(5);
    check("s3_no_early_pulse", 32'(bus.btn_pulse), 32'd0);
    tick();
    check("s3_pulse", 32'(bus.btn_pulse), 32'h10);
    check("s3_code",  32'(bus.btn_code),  32'd5);
    ticks(5);
    check("s3_one_pulse", 32'(dut_cnt[4]), 32'd1);
    raw = '0;
    ticks(10);

    // Simultaneous rises on bits 1 and 5, then bit 6 pressed while bit 1 held.
    clr_cnt();
    raw = 7'b0100010;
    ticks(6);
`ifdef BTN_SINGLE_PRESS_EN
    check("s4_pulse", 32'(bus.btn_pulse), 32'h02);
`else
    check("s4_pulse", 32'(bus.btn_pulse), 32'h22);
`endif
    check("s4_code", 32'(bus.btn_code), 32'd2);
    raw = 7'b0000010;
    ticks(8);
    raw = 7'b1000010;
    ticks(10);
`ifdef BTN_SINGLE_PRESS_EN
    check("s4_locked_out", 32'(dut_cnt[6]), 32'd0);
`else
    check("s4_independent", 32'(dut_cnt[6]), 32'd1);
`endif
    check("s4_level6", 32'(bus.btn_level[6]), 32'd1);
    raw = '0;
    ticks(10);

    // Reset mid-count on bit 3 while held: fresh press after release.
    raw = 7'b0001000;
    ticks(3);
    do_reset();
    clr_cnt();
    ticks(5);
    check("s5_no_early_pulse", 32'(bus.btn_pulse), 32'd0);
    tick();
    check("s5_pulse", 32'(bus.btn_pulse), 32'h08);
    raw = '0;
    ticks(10);

    // Long hold: exactly one pulse.
    clr_cnt();
    raw = 7'b0000001;
    ticks(1000);
    check("s6_one_pulse", 32'(dut_cnt[0]), 32'd1);
    check("s6_level",     32'(bus.btn_level), 32'h01);
    raw = '0;
    ticks(10);

    // Random bouncing, each bit held for 1..2D+2 cycles at a time.
    for (int i = 0; i < NUM_BTN; i++) hold[i] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (hold[i] == 0) begin
          raw[i]  = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 2 * D + 2));
        end
        hold[i]--;
      end
      tick();
    end
    raw = '0;
    ticks(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
